// File: rtl/fault_injector_n_pkg.sv
// Shared types and default widths for the programmable fault injector.
// Mode encoding matches the cfg_mode field driven by the test controller.
package fault_inj_pkg;

    localparam int FI_DATA_W_DEF = 8;
    localparam int FI_CNT_W_DEF  = 8;
    localparam int FI_EVT_W_DEF  = 8;

    typedef enum logic [1:0] {
        FI_NONE = 2'b00,
        FI_SA0  = 2'b01,
        FI_SA1  = 2'b10,
        FI_FLIP = 2'b11
    } fi_mode_t;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DELAY  = 2'b01,
        INJECT = 2'b10,
        DONE   = 2'b11
    } fi_state_t;

endpackage

// File: rtl/fault_injector_n_if.sv
// Configuration handshake between the test controller (master) and the injector (slave).
interface fault_injector_n_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_mode;
    logic [DATA_W-1:0] cfg_mask;
    logic [CNT_W-1:0]  cfg_delay;
    logic [CNT_W-1:0]  cfg_duration;

    modport master (
        output cfg_valid, cfg_mode, cfg_mask, cfg_delay, cfg_duration,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_mode, cfg_mask, cfg_delay, cfg_duration,
        output cfg_ready
    );
endinterface

// File: rtl/fi_corrupt.sv
// Combinational per-bit corruption datapath; only masked bits are touched,
// and only while the injection window is open.
module fi_corrupt
    import fault_inj_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [DATA_W-1:0] mask,
    input  fi_mode_t          mode,
    input  logic              active,
    output logic [DATA_W-1:0] data_o
);

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            logic bit_out;

            always_comb begin
                bit_out = data_i[gi];
                if (active && mask[gi]) begin
                    unique case (mode)
                        FI_SA0:  bit_out = 1'b0;
                        FI_SA1:  bit_out = 1'b1;
                        FI_FLIP: bit_out = ~data_i[gi];
                        default: bit_out = data_i[gi];
                    endcase
                end
            end

            assign data_o[gi] = bit_out;
        end
    endgenerate

endmodule

// File: rtl/fault_injector_n.sv
// Programmable inline fault injector: one armed injection per handshake,
// with start delay, duration window (0 = until abort) and a saturating event count.
module fault_injector_n
    import fault_inj_pkg::*;
#(
    parameter int DATA_W = FI_DATA_W_DEF,
    parameter int CNT_W  = FI_CNT_W_DEF,
    parameter int EVT_W  = FI_EVT_W_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    fault_injector_n_if.slave  cfg,
    input  logic [DATA_W-1:0]  data_i,
    output logic [DATA_W-1:0]  data_o,
    input  logic               abort_i,
    output logic               active_o,
    output logic               done_o,
    output logic [EVT_W-1:0]   evt_count_o
);

    fi_state_t         state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    fi_mode_t          mode_reg, mode_next;
    logic [DATA_W-1:0] mask_reg, mask_next;
    logic [CNT_W-1:0]  dur_reg, dur_next;
    logic [EVT_W-1:0]  evt_reg, evt_next;
    logic              accept;

    // Abort wins over a simultaneous offer, so the config is simply dropped.
    assign accept = cfg.cfg_valid && (state_reg == IDLE) && !abort_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            mode_reg  <= FI_NONE;
            mask_reg  <= '0;
            dur_reg   <= '0;
            evt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            mode_reg  <= mode_next;
            mask_reg  <= mask_next;
            dur_reg   <= dur_next;
            evt_reg   <= evt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mode_next  = mode_reg;
        mask_next  = mask_reg;
        dur_next   = dur_reg;
        evt_next   = evt_reg;

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    mode_next = fi_mode_t'(cfg.cfg_mode);
                    mask_next = cfg.cfg_mask;
                    dur_next  = cfg.cfg_duration;
                    if (cfg.cfg_delay != '0) begin
                        state_next = DELAY;
                        cnt_next   = cfg.cfg_delay - CNT_W'(1);
                    end else begin
                        state_next = INJECT;
                        cnt_next   = cfg.cfg_duration - CNT_W'(1);
                    end
                end
            end
            DELAY: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (cnt_reg == '0) begin
                    state_next = INJECT;
                    cnt_next   = dur_reg - CNT_W'(1);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end
            INJECT: begin
                // A zero duration holds the window open until abort.
                if (abort_i) begin
                    state_next = IDLE;
                end else if (dur_reg != '0) begin
                    if (cnt_reg == '0) begin
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                if (!abort_i && !(&evt_reg)) begin
                    evt_next = evt_reg + EVT_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign cfg.cfg_ready = (state_reg == IDLE);
    assign active_o      = (state_reg == INJECT);
    assign done_o        = (state_reg == DONE);
    assign evt_count_o   = evt_reg;

    fi_corrupt #(
        .DATA_W (DATA_W)
    ) u_corrupt (
        .data_i (data_i),
        .mask   (mask_reg),
        .mode   (mode_reg),
        .active (active_o),
        .data_o (data_o)
    );

endmodule

// File: tb/tb_fault_injector_n.sv
// Directed bench for fault_injector_n: table of full injection transactions
// plus hand sequences for abort, saturation and asynchronous reset.
module tb_fault_injector_n;
    import fault_inj_pkg::*;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int EVT_W  = 8;

    typedef struct {
        logic [1:0]        mode;
        logic [DATA_W-1:0] mask;
        int                delay;
        int                dur;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] exp_data;
    } vec_t;

    logic              clk = 1'b0;
    logic              rstn;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic              abort_i;
    logic              active_o;
    logic              done_o;
    logic [EVT_W-1:0]  evt_count_o;

    fault_injector_n_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) cfg_bus ();

    fault_injector_n #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W),
        .EVT_W  (EVT_W)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg         (cfg_bus),
        .data_i      (data_i),
        .data_o      (data_o),
        .abort_i     (abort_i),
        .active_o    (active_o),
        .done_o      (done_o),
        .evt_count_o (evt_count_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   exp_evt = 0;
    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [DATA_W-1:0] mask,
                           input int delay, input int dur, input logic [DATA_W-1:0] data);
        cfg_bus.cfg_mode     = mode;
        cfg_bus.cfg_mask     = mask;
        cfg_bus.cfg_delay    = CNT_W'(delay);
        cfg_bus.cfg_duration = CNT_W'(dur);
        data_i               = data;
    endtask

    function automatic void bump_evt();
        if (exp_evt < 255) exp_evt++;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int  total;
        logic exp_act;
        total = v.delay + v.dur;
        set_cfg(v.mode, v.mask, v.delay, v.dur, v.data);
        cfg_bus.cfg_valid = 1'b1;
        chk("ready_before_accept", cfg_bus.cfg_ready, 1'b1);
        tick();
        cfg_bus.cfg_valid = 1'b0;
        for (int j = 0; j <= total + 1; j++) begin
            if (j > 0) tick();
            exp_act = (j >= v.delay) && (j < total);
            chk("vec_active", active_o, exp_act);
            chk("vec_done", done_o, (j == total));
            chk("vec_data", data_o, exp_act ? v.exp_data : v.data);
            chk("vec_ready", cfg_bus.cfg_ready, (j == total + 1));
        end
        bump_evt();
        chk("vec_evt", evt_count_o, EVT_W'(exp_evt));
        $display("vec %0d mode=%0d mask=%02h delay=%0d dur=%0d data=%02h -> evt=%0d",
                 idx, v.mode, v.mask, v.delay, v.dur, v.data, evt_count_o);
    endtask

    // Shortest complete transaction: accept, one faulty cycle, DONE, back to IDLE.
    task automatic quick_txn();
        set_cfg(2'b00, 8'h00, 0, 1, 8'h00);
        cfg_bus.cfg_valid = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        tick();
        tick();
        bump_evt();
    endtask

    initial begin
        vecs[0] = '{mode: 2'b10, mask: 8'h0F, delay: 3,   dur: 2,   data: 8'hA0, exp_data: 8'hAF};
        vecs[1] = '{mode: 2'b11, mask: 8'hFF, delay: 0,   dur: 1,   data: 8'h3C, exp_data: 8'hC3};
        vecs[2] = '{mode: 2'b01, mask: 8'hF0, delay: 2,   dur: 3,   data: 8'hFF, exp_data: 8'h0F};
        vecs[3] = '{mode: 2'b00, mask: 8'hFF, delay: 1,   dur: 2,   data: 8'h5A, exp_data: 8'h5A};
        vecs[4] = '{mode: 2'b11, mask: 8'h00, delay: 0,   dur: 2,   data: 8'h77, exp_data: 8'h77};
        vecs[5] = '{mode: 2'b10, mask: 8'h81, delay: 4,   dur: 1,   data: 8'h00, exp_data: 8'h81};
        vecs[6] = '{mode: 2'b11, mask: 8'h0F, delay: 255, dur: 1,   data: 8'h12, exp_data: 8'h1D};
        vecs[7] = '{mode: 2'b01, mask: 8'h01, delay: 0,   dur: 255, data: 8'h03, exp_data: 8'h02};

        rstn              = 1'b0;
        abort_i           = 1'b0;
        cfg_bus.cfg_valid = 1'b0;
        set_cfg(2'b00, 8'h00, 0, 0, 8'hA5);
        tick();
        tick();
        rstn = 1'b1;
        tick();
        chk("rst_data", data_o, 8'hA5);
        chk("rst_ready", cfg_bus.cfg_ready, 1'b1);
        chk("rst_active", active_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_evt", evt_count_o, 8'd0);
        $display("reset: data_o=%02h ready=%0b evt=%0d", data_o, cfg_bus.cfg_ready, evt_count_o);

        for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

        // Permanent stuck-at-0 window, then abort.
        set_cfg(2'b01, 8'hF0, 0, 0, 8'hFF);
        cfg_bus.cfg_valid = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("perm_data", data_o, 8'h0F);
            chk("perm_active", active_o, 1'b1);
            tick();
        end
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("perm_abort_active", active_o, 1'b0);
        chk("perm_abort_data", data_o, 8'hFF);
        chk("perm_abort_done", done_o, 1'b0);
        chk("perm_abort_ready", cfg_bus.cfg_ready, 1'b1);
        tick();
        chk("perm_abort_done2", done_o, 1'b0);
        chk("perm_abort_evt", evt_count_o, EVT_W'(exp_evt));
        $display("perm stuck-at-0 aborted: data_o=%02h evt=%0d", data_o, evt_count_o);

        // Abort during DELAY, new config held valid is taken right after.
        set_cfg(2'b10, 8'hFF, 5, 2, 8'h00);
        cfg_bus.cfg_valid = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        chk("dly_abort_active0", active_o, 1'b0);
        tick();
        chk("dly_abort_active1", active_o, 1'b0);
        abort_i = 1'b1;
        set_cfg(2'b11, 8'hFF, 0, 1, 8'h3C);
        cfg_bus.cfg_valid = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("dly_abort_active2", active_o, 1'b0);
        chk("dly_abort_ready", cfg_bus.cfg_ready, 1'b1);
        chk("dly_abort_data", data_o, 8'h3C);
        tick();
        cfg_bus.cfg_valid = 1'b0;
        chk("dly_new_active", active_o, 1'b1);
        chk("dly_new_data", data_o, 8'hC3);
        chk("dly_new_ready", cfg_bus.cfg_ready, 1'b0);
        tick();
        chk("dly_new_done", done_o, 1'b1);
        chk("dly_new_data_after", data_o, 8'h3C);
        tick();
        bump_evt();
        chk("dly_new_evt", evt_count_o, EVT_W'(exp_evt));
        $display("delay abort + re-arm: evt=%0d", evt_count_o);

        // Abort in IDLE coinciding with an offer drops the config.
        set_cfg(2'b11, 8'hFF, 0, 1, 8'h3C);
        cfg_bus.cfg_valid = 1'b1;
        abort_i = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        abort_i = 1'b0;
        chk("idle_abort_active", active_o, 1'b0);
        chk("idle_abort_data", data_o, 8'h3C);
        chk("idle_abort_ready", cfg_bus.cfg_ready, 1'b1);
        tick();
        chk("idle_abort_done", done_o, 1'b0);
        $display("idle abort with offer: active=%0b ready=%0b", active_o, cfg_bus.cfg_ready);

        // Abort in DONE suppresses the increment.
        cfg_bus.cfg_valid = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        chk("done_abort_active", active_o, 1'b1);
        tick();
        chk("done_abort_done", done_o, 1'b1);
        chk("done_abort_ready0", cfg_bus.cfg_ready, 1'b0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        chk("done_abort_done_after", done_o, 1'b0);
        chk("done_abort_ready1", cfg_bus.cfg_ready, 1'b1);
        chk("done_abort_evt", evt_count_o, EVT_W'(exp_evt));
        $display("abort in DONE: evt=%0d", evt_count_o);

        // Drive the event counter to saturation.
        while (exp_evt < 255) quick_txn();
        chk("sat_evt_full", evt_count_o, 8'hFF);
        quick_txn();
        chk("sat_evt_hold", evt_count_o, 8'hFF);
        $display("saturation: evt=%0d", evt_count_o);

        // Asynchronous reset between edges while the window is open.
        set_cfg(2'b10, 8'hFF, 0, 0, 8'h00);
        cfg_bus.cfg_valid = 1'b1;
        tick();
        cfg_bus.cfg_valid = 1'b0;
        chk("arst_pre_data", data_o, 8'hFF);
        chk("arst_pre_active", active_o, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_data", data_o, 8'h00);
        chk("arst_active", active_o, 1'b0);
        chk("arst_evt", evt_count_o, 8'd0);
        chk("arst_ready", cfg_bus.cfg_ready, 1'b1);
        #2;
        rstn = 1'b1;
        tick();
        chk("arst_post_active", active_o, 1'b0);
        $display("async reset mid-inject: data_o=%02h active=%0b evt=%0d",
                 data_o, active_o, evt_count_o);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fault_injector_n.md
Name: fault_injector_n

Overview:
- Parametrised, programmable fault-injection block. It sits inline on a DATA_W-bit signal path between a driving stage and its consumer, under test-controller control.
- A configuration handshake arms one injection: fault mode, bit mask, start delay and duration.
- A small FSM applies the fault to the masked bits for exactly the programmed window, then reports completion.
- Successor to the fixed two-output injection block: it adds width, programmable timing, selectable fault modes and event counting.

Parameters:
- DATA_W, 8, width of the protected data path (1..64).
- CNT_W, 8, width of the delay and duration counters.
- EVT_W, 8, width of the completed-injection counter.

Ports:
- clk  in  1  system clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- data_i  in  DATA_W  fault-free data from upstream
- data_o  out  DATA_W  data to downstream, corrupted while the window is active
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  block can accept configuration (high only in IDLE)
- cfg_mode  in  2  00 none (timing only), 01 stuck-at-0, 10 stuck-at-1, 11 bit-flip
- cfg_mask  in  DATA_W  bits to corrupt
- cfg_delay  in  CNT_W  cycles from acceptance to first faulty cycle
- cfg_duration  in  CNT_W  faulty cycles; 0 = permanent until abort
- abort_i  in  1  cancel any armed or active injection
- active_o  out  1  injection window open this cycle
- done_o  out  1  one-cycle pulse when a window completes normally
- evt_count_o  out  EVT_W  number of completed injections, saturating

Behaviour:
- Reset (rstn=0, asynchronous):
  - FSM goes to IDLE.
  - Counters and the registered config are cleared; evt_count_o=0.
  - Outputs: cfg_ready=1, active_o=0, done_o=0, data_o=data_i.
- Handshake:
  - Config is accepted on a rising edge with cfg_valid&cfg_ready.
  - mode, mask, delay and duration are latched at that edge.
  - The cfg_* inputs are ignored in every other state.
- FSM states and transitions:
  - IDLE: acceptance goes to DELAY if delay>0, otherwise straight to INJECT.
  - DELAY: down-counter loads delay-1 on acceptance. Go to INJECT on the edge where the counter is 0, else decrement.
  - INJECT: active_o=1.
    - duration>0: down-counter loads duration-1 on entry. Go to DONE on the edge where the counter is 0.
    - duration=0: stay in INJECT until abort.
  - DONE: done_o=1 for one cycle, evt_count increments (saturates at all-ones), then return to IDLE. cfg_ready=0 in DONE.
- Timing: if acceptance is at edge T, active_o is high from after edge T+delay through the cycle before edge T+delay+duration. That is exactly `duration` cycles. done_o is high in the following cycle.
- data_o is combinational, zero latency:
  - active_o=0: data_o=data_i.
  - mode 00: data_o=data_i (window and counting still occur).
  - mode 01: data_o = data_i & ~mask.
  - mode 10: data_o = data_i | mask.
  - mode 11: data_o = data_i ^ mask.
  - mask=0 gives data_o=data_i in all modes.
- Abort:
  - abort_i=1 at an edge in DELAY, INJECT or DONE returns the FSM to IDLE.
  - active_o drops after that edge. No done_o pulse and no evt_count increment.
  - Abort in DONE suppresses that cycle's increment.
  - Abort in IDLE has no effect, and abort has priority over a simultaneous cfg acceptance (the config is dropped).
- Counters: the maximum delay or duration value (2^CNT_W-1) is legal and must not wrap early.
- Reset mid-operation clears everything immediately, including an open window. data_o reverts to data_i asynchronously.

Decomposition:
- Package fault_inj_pkg holds:
  - the mode enum (FI_NONE, FI_SA0, FI_SA1, FI_FLIP);
  - the FSM state enum (IDLE, DELAY, INJECT, DONE);
  - the default width constants.
- One natural sub-module, fi_corrupt: a purely combinational mode/mask datapath (data_i, mask, mode, active -> data_o). FSM and counters stay in the top.

Test Plan:
- Reset then data_i=8'hA5, no config -> data_o=8'hA5, cfg_ready=1, active_o=0, evt_count_o=0.
- Stuck-at-1, mask=8'h0F, delay=3, duration=2, data_i=8'hA0, accepted at edge T -> data_o=8'hAF only in the 2 cycles after edges T+3 and T+4. done_o pulses once after T+5; evt_count_o=1.
- Bit-flip, mask=8'hFF, delay=0, duration=1, data_i=8'h3C -> data_o=8'hC3 for exactly the cycle after acceptance; cfg_ready=0 until done.
- Stuck-at-0, mask=8'hF0, duration=0, data_i=8'hFF -> data_o=8'h0F indefinitely. Abort -> data_o=8'hFF next cycle, no done_o, evt_count unchanged.
- Abort asserted during DELAY (delay=5, aborted at 2) -> active_o never rises; cfg_valid with cfg_ready held high for a new config is accepted the next cycle.
- Reset asserted mid-INJECT, asynchronously between edges -> data_o returns to data_i and active_o drops immediately; evt_count_o=0.
